// File: rtl/iomem_arbiter.sv
// PicoSoC iomem window controller: decodes addr[23:20] into peripheral slots,
// runs one valid/ready transaction at a time and completes hung or unmapped slots with ERR_DATA.
module iomem_arbiter #(
    parameter int          NSLOTS   = 4,
    parameter logic [7:0]  BASE     = 8'h03,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [3:0]             m_wstrb,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    output logic [31:0]            m_rdata,
    output logic [NSLOTS-1:0]      s_valid,
    input  logic [NSLOTS-1:0]      s_ready,
    output logic [3:0]             s_wstrb,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    input  logic [32*NSLOTS-1:0]   s_rdata,
    output logic                   err_irq,
    output logic [7:0]             err_cnt
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    slot;
    logic [TW-1:0] timer;

    logic [3:0]    req_slot;
    logic          req_hit;
    logic          req_mapped;
    logic          sel_ready;
    logic [31:0]   sel_rdata;

    assign req_slot   = m_addr[23:20];
    assign req_hit    = m_valid && !m_ready && (m_addr[31:24] == BASE);
    assign req_mapped = ({28'd0, req_slot} < 32'(NSLOTS));

    // Only the slot owning the current transaction can complete it.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (slot == 4'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            slot    <= '0;
            timer   <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
            s_valid <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            err_irq <= 1'b0;
            err_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_hit) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        slot    <= req_slot;
                        timer   <= '0;
                        if (req_mapped) begin
                            for (int i = 0; i < NSLOTS; i++) begin
                                s_valid[i] <= (req_slot == 4'(i));
                            end
                            state <= ST_BUSY;
                        end else begin
                            m_rdata <= ERR_DATA;
                            m_ready <= 1'b1;
                            err_irq <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            state <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    // A slot answering on the timeout edge still wins.
                    if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        state   <= ST_DONE;
                    end else if (timer == TMAX) begin
                        m_rdata <= ERR_DATA;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        err_irq <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= ST_DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DONE: begin
                    m_ready <= 1'b0;
                    err_irq <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: directed transactions push expected responses,
// a negedge monitor pops and checks them whenever m_ready is presented.
module tb_iomem_arbiter;

    localparam int          NSLOTS  = 4;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 m_valid = 1'b0;
    logic                 m_ready;
    logic [3:0]           m_wstrb = '0;
    logic [31:0]          m_addr = '0;
    logic [31:0]          m_wdata = '0;
    logic [31:0]          m_rdata;
    logic [NSLOTS-1:0]    s_valid;
    logic [NSLOTS-1:0]    s_ready = '0;
    logic [3:0]           s_wstrb;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic [32*NSLOTS-1:0] s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    logic                 err_irq;
    logic [7:0]           err_cnt;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .NSLOTS  (NSLOTS),
        .BASE    (8'h03),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_wstrb(m_wstrb),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_wstrb(s_wstrb),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .err_irq(err_irq),
        .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every m_ready must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (m_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got m_ready=1 expected no response (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_rdata", m_rdata, e.rdata);
                    chk("rsp_err_irq", 32'(err_irq), 32'(e.err));
                end
            end else if (err_irq) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_err_irq: got err_irq=1 with m_ready=0 expected 0 (t=%0t)", $time);
            end
            if (s_valid != '0) begin
                chk("s_valid_onehot", 32'($countones(s_valid)), 32'd1);
            end
        end
    end

    task automatic xact(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int rdy_slot, input int rdy_edge,
                        input logic [31:0] rdata, input logic [NSLOTS-1:0] noise,
                        input logic [NSLOTS-1:0] exp_sv, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_svc);
        int lat;
        int svc;
        exp_t e;
        lat = -1;
        svc = 0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sbq.push_back(e);
        m_addr  = addr;
        m_wstrb = wstrb;
        m_wdata = wdata;
        m_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                chk({name, "_s_valid"}, 32'(s_valid), 32'(exp_sv));
                chk({name, "_s_addr"}, s_addr, addr);
                chk({name, "_s_wdata"}, s_wdata, wdata);
                chk({name, "_s_wstrb"}, 32'(s_wstrb), 32'(wstrb));
            end
            if (s_valid != '0) svc++;
            if (m_ready) begin
                lat = k;
                break;
            end
            if (k == 0) s_ready = s_ready | noise;
            if (rdy_slot >= 0 && k + 1 == rdy_edge) begin
                s_ready[rdy_slot] = 1'b1;
                s_rdata[32*rdy_slot +: 32] = rdata;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_s_valid_cycles"}, 32'(svc), 32'(exp_svc));
        m_valid = 1'b0;
        s_ready = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err_irq", 32'(err_irq), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        xact("rd_s1", 32'h0310_0004, 4'b0000, 32'h0, 1, 3, 32'h1234_5678, 4'b0000,
             4'b0010, 32'h1234_5678, 1'b0, 3, 3);
        xact("wr_s0", 32'h0300_0000, 4'b0011, 32'hA5A5_00FF, 0, 1, 32'hCAFE_0000, 4'b0000,
             4'b0001, 32'hCAFE_0000, 1'b0, 1, 1);
        xact("tmo_s2", 32'h0320_0000, 4'b0000, 32'h0, -1, 0, 32'h0, 4'b0000,
             4'b0100, ERR, 1'b1, TIMEOUT, TIMEOUT);
        chk("tmo_err_cnt", 32'(err_cnt), 32'd1);

        m_addr  = 32'h0200_0000;
        m_wstrb = 4'b0000;
        m_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("foreign_s_valid", 32'(s_valid), 32'd0);
            chk("foreign_m_ready", 32'(m_ready), 32'd0);
        end
        m_valid = 1'b0;

        xact("noise_s3", 32'h0310_0008, 4'b0000, 32'h0, 1, 4, 32'h5555_AAAA, 4'b1000,
             4'b0010, 32'h5555_AAAA, 1'b0, 4, 4);
        xact("rdy_on_tmo", 32'h0320_0010, 4'b0000, 32'h0, 2, TIMEOUT, 32'h7777_8888, 4'b0000,
             4'b0100, 32'h7777_8888, 1'b0, TIMEOUT, TIMEOUT);
        chk("rdy_on_tmo_err_cnt", 32'(err_cnt), 32'd1);

        xact("unmapped", 32'h0370_0000, 4'b0000, 32'h0, -1, 0, 32'h0, 4'b0000,
             4'b0000, ERR, 1'b1, 0, 0);
        chk("unmapped_err_cnt", 32'(err_cnt), 32'd2);
        for (int r = 0; r < 299; r++) begin
            xact("unmapped_rep", 32'h0370_0000, 4'b0000, 32'h0, -1, 0, 32'h0, 4'b0000,
                 4'b0000, ERR, 1'b1, 0, 0);
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        m_addr  = 32'h0300_0010;
        m_wstrb = 4'b0000;
        m_wdata = 32'h0;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rstbusy_s_valid_before", 32'(s_valid), 32'b0001);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        m_valid = 1'b0;
        chk("rstbusy_s_valid", 32'(s_valid), 32'd0);
        chk("rstbusy_m_ready", 32'(m_ready), 32'd0);
        chk("rstbusy_s_addr", s_addr, 32'd0);
        chk("rstbusy_m_rdata", m_rdata, 32'd0);
        chk("rstbusy_err_cnt", 32'(err_cnt), 32'd0);
        chk("rstbusy_err_irq", 32'(err_irq), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        xact("post_rst_s0", 32'h0300_0020, 4'b1111, 32'h0102_0304, 0, 1, 32'h9999_0000, 4'b0000,
             4'b0001, 32'h9999_0000, 1'b0, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
